// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX round-robin arbiter: FSM encoding,
// counter width and the clog2 helper used to size requester ids.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      width = width + 32'sd1;
    end
    if (width == 32'sd0) begin
      width = 32'sd1;
    end else begin
      width = width;
    end
    return width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester with req set, searching
// upward from ptr+1 and wrapping, using a doubled request vector.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  localparam logic [IDW:0] LAST_ID   = (IDW+1)'(NUM_REQ - 1);
  localparam logic [IDW:0] ONE_ID    = (IDW+1)'(1);
  localparam logic [IDW:0] NUM_REQ_W = (IDW+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [IDW:0]         start_s;
  logic [IDW:0]         off_s;
  logic [IDW:0]         sum_s;

  // Rotate the doubled vector so bit 0 is the requester just after ptr.
  always_comb begin
    if ({1'b0, ptr} >= LAST_ID) begin
      start_s = '0;
    end else begin
      start_s = {1'b0, ptr} + ONE_ID;
    end
    dbl_s = {req, req};
    rot_s = NUM_REQ'(dbl_s >> start_s);
  end

  // Lowest set bit of the rotated vector, mapped back to a requester id.
  always_comb begin
    any   = |rot_s;
    off_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? (IDW+1)'(i) : off_s;
    end
    sum_s = start_s + off_s;
    if (sum_s >= NUM_REQ_W) begin
      gnt_id = IDW'(sum_s - NUM_REQ_W);
    end else begin
      gnt_id = IDW'(sum_s);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX byte port among NUM_REQ requesters;
// a grant lasts for a whole frame (last) or at most MAX_BURST bytes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      io_axiClk,
  input  logic                      io_resetn,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_data,
  input  logic [NUM_REQ-1:0]        io_req_last,
  output logic [NUM_REQ-1:0]        io_req_ready,
  output logic                      io_tx_valid,
  output logic [DATA_W-1:0]         io_tx_data,
  input  logic                      io_tx_ready,
  output logic [clog2(NUM_REQ)-1:0] io_grant_id,
  output logic                      io_busy,
  output logic                      io_burst_cut
);

  localparam int               IDW      = clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDW-1:0]   PTR_RST  = IDW'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cut_q, cut_d;

  logic [IDW-1:0]    pick_id_s;
  logic              pick_any_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (io_req_valid),
    .ptr    (ptr_q),
    .gnt_id (pick_id_s),
    .any    (pick_any_s)
  );

  always_comb begin
    sel_valid_s = io_req_valid[grant_q];
    sel_last_s  = io_req_last[grant_q];
    sel_data_s  = io_req_data[int'(grant_q)*DATA_W +: DATA_W];
  end

  // Next-state logic plus the combinational TX datapath while a grant is held.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    cut_d        = 1'b0;
    io_tx_valid  = 1'b0;
    io_tx_data   = '0;
    io_req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_any_s) begin
          grant_d = pick_id_s;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        io_tx_valid           = sel_valid_s;
        io_tx_data            = sel_data_s;
        io_req_ready[grant_q] = io_tx_ready;
        if (sel_valid_s && io_tx_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          // last takes precedence over the burst limit, so no cut pulse then.
          if (sel_last_s || (cnt_q == CNT_LAST)) begin
            state_d = ST_IDLE;
            ptr_d   = grant_q;
            cut_d   = ~sel_last_s;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge io_axiClk) begin
    if (!io_resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      cut_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cut_q   <= cut_d;
    end
  end

  assign io_busy      = (state_q == ST_XFER);
  assign io_grant_id  = grant_q;
  assign io_burst_cut = cut_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              io_resetn;
  logic [NR-1:0]     io_req_valid;
  logic [NR*DW-1:0]  io_req_data;
  logic [NR-1:0]     io_req_last;
  logic [NR-1:0]     io_req_ready;
  logic              io_tx_valid;
  logic [DW-1:0]     io_tx_data;
  logic              io_tx_ready;
  logic [1:0]        io_grant_id;
  logic              io_busy;
  logic              io_burst_cut;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MAXB)
  ) dut (
    .io_axiClk    (clk),
    .io_resetn    (io_resetn),
    .io_req_valid (io_req_valid),
    .io_req_data  (io_req_data),
    .io_req_last  (io_req_last),
    .io_req_ready (io_req_ready),
    .io_tx_valid  (io_tx_valid),
    .io_tx_data   (io_tx_data),
    .io_tx_ready  (io_tx_ready),
    .io_grant_id  (io_grant_id),
    .io_busy      (io_busy),
    .io_burst_cut (io_burst_cut)
  );

  int n_cmp = 0;
  int n_err = 0;

  // stimulus controls
  logic          rst_v;
  logic          txr_v;
  logic [NR-1:0] gap_v;
  logic [NR-1:0] held_v;

  // per-requester byte sources: {last, data}
  logic [8:0] src_mem [NR][256];
  int         src_rd  [NR];
  int         src_wr  [NR];

  // reference model: who owns the port, who owned it last, bytes sent in grant
  bit          m_busy;
  int          m_gid;
  int          m_ptr;
  int          m_sent;
  bit          m_cut;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [NR-1:0] exp_ready;

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_wr[r] & 255] = {l, d};
    src_wr[r] = src_wr[r] + 1;
  endtask

  task automatic drive_sample();
    @(negedge clk);
    io_resetn   = rst_v;
    io_tx_ready = txr_v;
    for (int r = 0; r < NR; r++) begin
      if ((src_wr[r] != src_rd[r]) && !gap_v[r]) begin
        io_req_valid[r] = 1'b1;
        {io_req_last[r], io_req_data[r*DW +: DW]} = src_mem[r][src_rd[r] & 255];
      end else begin
        io_req_valid[r]         = 1'b0;
        io_req_last[r]          = 1'b0;
        io_req_data[r*DW +: DW] = 8'h00;
      end
    end
    #1;
    exp_valid = m_busy && io_req_valid[m_gid];
    exp_data  = m_busy ? io_req_data[m_gid*DW +: DW] : 8'h00;
    exp_ready = (m_busy && io_tx_ready) ? (4'b0001 << m_gid) : 4'b0000;
  endtask

  task automatic model_step();
    bit found;
    bit cut_nx;
    found  = 1'b0;
    cut_nx = 1'b0;
    if (!rst_v) begin
      m_busy = 1'b0; m_gid = 0; m_ptr = NR - 1; m_sent = 0; m_cut = 1'b0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (!found && io_req_valid[c]) begin
          found = 1'b1; m_busy = 1'b1; m_gid = c; m_sent = 0;
        end
      end
      m_cut = 1'b0;
    end else begin
      if (io_req_valid[m_gid] && io_tx_ready) begin
        m_sent = m_sent + 1;
        if (io_req_last[m_gid] || (m_sent == MAXB)) begin
          m_busy = 1'b0;
          m_ptr  = m_gid;
          cut_nx = !io_req_last[m_gid];
        end
      end
      m_cut = cut_nx;
    end
  endtask

  task automatic commit();
    for (int r = 0; r < NR; r++) begin
      held_v[r] = io_req_valid[r] && !io_req_ready[r];
      if (io_req_valid[r] && io_req_ready[r]) src_rd[r] = src_rd[r] + 1;
    end
    model_step();
    @(posedge clk);
  endtask

  task automatic apply_reset();
    rst_v = 1'b0; txr_v = 1'b1; gap_v = '0;
    for (int r = 0; r < NR; r++) src_rd[r] = src_wr[r];
    repeat (2) begin drive_sample(); commit(); end
    rst_v = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive_sample();
    n_cmp++; if (io_tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", io_tx_valid); end
    n_cmp++; if (io_req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", io_req_ready); end
    n_cmp++; if (io_tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", io_tx_data); end
    n_cmp++; if (io_grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", io_grant_id); end
    n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", io_busy); end
    n_cmp++; if (io_burst_cut !== 1'b0) begin n_err++; $display("FAIL reset_burst_cut: got %b want 0", io_burst_cut); end
    commit();
  endtask

  task automatic test_single_frame();
    logic [7:0] eb;
    apply_reset();
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    drive_sample(); commit();
    for (int k = 0; k < 3; k++) begin
      eb = 8'h41 + 8'(k);
      drive_sample();
      n_cmp++; if (io_tx_valid !== 1'b1) begin n_err++; $display("FAIL single_tx_valid[%0d]: got %b want 1", k, io_tx_valid); end
      n_cmp++; if (io_tx_data !== eb) begin n_err++; $display("FAIL single_tx_data[%0d]: got %h want %h", k, io_tx_data, eb); end
      n_cmp++; if (io_grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant[%0d]: got %0d want 2", k, io_grant_id); end
      n_cmp++; if (io_req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready[%0d]: got %b want 0100", k, io_req_ready); end
      commit();
    end
    drive_sample();
    n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", io_busy); end
    commit();
  endtask

  task automatic test_round_robin();
    int r;
    logic [7:0] eb;
    apply_reset();
    for (int q = 0; q < NR; q++) begin
      push(q, 8'(16*q), 1'b1); push(q, 8'(16*q + 1), 1'b1);
    end
    for (int g = 0; g < 5; g++) begin
      r  = g % NR;
      eb = 8'(16*r + g/NR);
      drive_sample();
      n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL rr_bubble[%0d]: got busy %b want 0", g, io_busy); end
      commit();
      drive_sample();
      n_cmp++; if (io_grant_id !== 2'(r)) begin n_err++; $display("FAIL rr_grant[%0d]: got %0d want %0d", g, io_grant_id, r); end
      n_cmp++; if (io_tx_data !== eb) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", g, io_tx_data, eb); end
      commit();
    end
  endtask

  task automatic test_burst_cut();
    apply_reset();
    for (int k = 0; k < 6; k++) push(1, 8'hB0 + 8'(k), 1'b0);
    push(2, 8'h2A, 1'b1); push(3, 8'h3A, 1'b1);
    drive_sample(); commit();
    for (int k = 0; k < MAXB; k++) begin
      drive_sample();
      n_cmp++; if (io_tx_data !== 8'hB0 + 8'(k)) begin n_err++; $display("FAIL burst_data[%0d]: got %h want %h", k, io_tx_data, 8'hB0 + 8'(k)); end
      n_cmp++; if (io_burst_cut !== 1'b0) begin n_err++; $display("FAIL burst_cut_early[%0d]: got %b want 0", k, io_burst_cut); end
      commit();
    end
    drive_sample();
    n_cmp++; if (io_burst_cut !== 1'b1) begin n_err++; $display("FAIL burst_cut_pulse: got %b want 1", io_burst_cut); end
    n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL burst_busy_release: got %b want 0", io_busy); end
    commit();
    drive_sample();
    n_cmp++; if (io_burst_cut !== 1'b0) begin n_err++; $display("FAIL burst_cut_width: got %b want 0", io_burst_cut); end
    n_cmp++; if (io_grant_id !== 2'd2) begin n_err++; $display("FAIL burst_next_grant: got %0d want 2", io_grant_id); end
    commit();
    drive_sample(); commit();
    drive_sample();
    n_cmp++; if (io_grant_id !== 2'd3) begin n_err++; $display("FAIL burst_third_grant: got %0d want 3", io_grant_id); end
    commit();
    drive_sample(); commit();
    drive_sample();
    n_cmp++; if (io_grant_id !== 2'd1) begin n_err++; $display("FAIL burst_regrant: got %0d want 1", io_grant_id); end
    n_cmp++; if (io_tx_data !== 8'hB4) begin n_err++; $display("FAIL burst_resume_data: got %h want b4", io_tx_data); end
    commit();
  endtask

  task automatic test_last_at_limit();
    apply_reset();
    for (int k = 0; k < MAXB; k++) push(2, 8'h60 + 8'(k), (k == MAXB - 1));
    drive_sample(); commit();
    repeat (MAXB) begin drive_sample(); commit(); end
    drive_sample();
    n_cmp++; if (io_burst_cut !== 1'b0) begin n_err++; $display("FAIL limit_last_cut: got %b want 0", io_burst_cut); end
    n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL limit_last_busy: got %b want 0", io_busy); end
    commit();
  endtask

  task automatic test_backpressure();
    bit   pat [5];
    int   idx;
    logic [NR-1:0] er;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idx = 0;
    apply_reset();
    push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b0); push(3, 8'hC2, 1'b1);
    drive_sample(); commit();
    for (int c = 0; c < 5; c++) begin
      txr_v = pat[c];
      er    = pat[c] ? 4'b1000 : 4'b0000;
      drive_sample();
      n_cmp++; if (io_req_ready !== er) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want %b", c, io_req_ready, er); end
      n_cmp++; if (io_tx_data !== 8'hC0 + 8'(idx)) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", c, io_tx_data, 8'hC0 + 8'(idx)); end
      n_cmp++; if (io_tx_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, io_tx_valid); end
      commit();
      if (pat[c]) idx++;
    end
    txr_v = 1'b1;
    drive_sample();
    n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_end: got %b want 0", io_busy); end
    commit();
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    for (int k = 0; k < 5; k++) push(1, 8'hD0 + 8'(k), (k == 4));
    push(3, 8'h3D, 1'b1);
    drive_sample(); commit();
    repeat (2) begin
      drive_sample();
      n_cmp++; if (io_grant_id !== 2'd1) begin n_err++; $display("FAIL rst_mid_grant: got %0d want 1", io_grant_id); end
      commit();
    end
    rst_v = 1'b0;
    drive_sample(); commit();
    rst_v = 1'b1;
    drive_sample();
    n_cmp++; if (io_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", io_busy); end
    n_cmp++; if (io_grant_id !== 2'd0) begin n_err++; $display("FAIL rst_mid_gid: got %0d want 0", io_grant_id); end
    n_cmp++; if (io_tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", io_tx_valid); end
    n_cmp++; if (io_req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0000", io_req_ready); end
    n_cmp++; if (io_tx_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %h want 00", io_tx_data); end
    commit();
    drive_sample();
    n_cmp++; if (io_grant_id !== 2'd1) begin n_err++; $display("FAIL rst_mid_regrant: got %0d want 1", io_grant_id); end
    n_cmp++; if (io_busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_rebusy: got %b want 1", io_busy); end
    commit();
  endtask

  task automatic test_stall();
    apply_reset();
    push(0, 8'hE0, 1'b0); push(0, 8'hE1, 1'b0); push(0, 8'hE2, 1'b1);
    push(2, 8'h2E, 1'b1);
    drive_sample(); commit();
    drive_sample();
    n_cmp++; if (io_tx_data !== 8'hE0) begin n_err++; $display("FAIL stall_first: got %h want e0", io_tx_data); end
    commit();
    gap_v[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_sample();
      n_cmp++; if (io_tx_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 0", c, io_tx_valid); end
      n_cmp++; if (io_grant_id !== 2'd0) begin n_err++; $display("FAIL stall_gid[%0d]: got %0d want 0", c, io_grant_id); end
      n_cmp++; if (io_req_ready !== 4'b0001) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0001", c, io_req_ready); end
      commit();
    end
    gap_v[0] = 1'b0;
    for (int k = 1; k < 3; k++) begin
      drive_sample();
      n_cmp++; if (io_tx_data !== 8'hE0 + 8'(k)) begin n_err++; $display("FAIL stall_resume[%0d]: got %h want %h", k, io_tx_data, 8'hE0 + 8'(k)); end
      commit();
    end
    drive_sample(); commit();
    drive_sample();
    n_cmp++; if (io_grant_id !== 2'd2) begin n_err++; $display("FAIL stall_next_grant: got %0d want 2", io_grant_id); end
    commit();
  endtask

  task automatic test_random();
    int len;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        if ((src_wr[r] - src_rd[r] < 4) && ($urandom_range(0, 3) == 0)) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) push(r, 8'($urandom), (b == len - 1));
        end
      end
      txr_v = ($urandom_range(0, 9) < 7);
      for (int r = 0; r < NR; r++) gap_v[r] = !held_v[r] && ($urandom_range(0, 7) == 0);
      rst_v = ($urandom_range(0, 499) != 0);
      drive_sample();
      n_cmp++; if (io_tx_valid !== exp_valid) begin n_err++; $display("FAIL rnd_tx_valid cyc=%0d: got %b want %b", cyc, io_tx_valid, exp_valid); end
      n_cmp++; if (io_tx_data !== exp_data) begin n_err++; $display("FAIL rnd_tx_data cyc=%0d: got %h want %h", cyc, io_tx_data, exp_data); end
      n_cmp++; if (io_req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_req_ready cyc=%0d: got %b want %b", cyc, io_req_ready, exp_ready); end
      n_cmp++; if (io_grant_id !== 2'(m_gid)) begin n_err++; $display("FAIL rnd_grant cyc=%0d: got %0d want %0d", cyc, io_grant_id, m_gid); end
      n_cmp++; if (io_busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, io_busy, m_busy); end
      n_cmp++; if (io_burst_cut !== m_cut) begin n_err++; $display("FAIL rnd_burst_cut cyc=%0d: got %b want %b", cyc, io_burst_cut, m_cut); end
      commit();
    end
    rst_v = 1'b1;
  endtask

  initial begin
    io_resetn    = 1'b0;
    io_req_valid = '0;
    io_req_data  = '0;
    io_req_last  = '0;
    io_tx_ready  = 1'b0;
    rst_v  = 1'b0;
    txr_v  = 1'b1;
    gap_v  = '0;
    held_v = '0;
    for (int r = 0; r < NR; r++) begin src_rd[r] = 0; src_wr[r] = 0; end
    m_busy = 1'b0; m_gid = 0; m_ptr = NR - 1; m_sent = 0; m_cut = 1'b0;

    test_reset();
    test_single_frame();
    test_round_robin();
    test_burst_cut();
    test_last_at_limit();
    test_backpressure();
    test_reset_mid_frame();
    test_stall();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
